// File: rtl/demux2_stream_if.sv
// demux2_stream_if: handshake bundle for the two-way stream demux
// master drives d/s/in_valid and the channel readies; slave (the demux) drives
// in_ready, the registered channel words/valids and the per-channel transfer counts.
interface demux2_stream_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] d;
  logic              s;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] y0;
  logic [DATA_W-1:0] y1;
  logic              y0_valid;
  logic              y1_valid;
  logic              y0_ready;
  logic              y1_ready;
  logic [7:0]        cnt0;
  logic [7:0]        cnt1;
  modport master (
    output d, s, in_valid, y0_ready, y1_ready,
    input  in_ready, y0, y1, y0_valid, y1_valid, cnt0, cnt1
  );
  modport slave (
    input  d, s, in_valid, y0_ready, y1_ready,
    output in_ready, y0, y1, y0_valid, y1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/demux2_stream.sv
// demux2_stream: routes one input stream to two one-entry registered output channels
// clk/rst_n: clock and async active-low reset; bus: demux2_stream_if slave
// (d, s, in_valid -> in_ready; y0/y1 with valid/ready; cnt0/cnt1 output transfer counts).
module demux2_stream #(parameter int DATA_W = 8) (
  input logic             clk,
  input logic             rst_n,
  demux2_stream_if.slave  bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;
  state_e            st0_q, st0_d, st1_q, st1_d;
  logic [DATA_W-1:0] y0_q, y0_d, y1_q, y1_d;
  logic [7:0]        cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic              rdy, ld0, ld1, out0, out1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st0_q  <= EMPTY;
      st1_q  <= EMPTY;
      y0_q   <= '0;
      y1_q   <= '0;
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      st0_q  <= st0_d;
      st1_q  <= st1_d;
      y0_q   <= y0_d;
      y1_q   <= y1_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end
  // A channel can take a word when empty or when its held word leaves this cycle.
  always_comb begin
    out0   = (st0_q == FULL) && bus.y0_ready;
    out1   = (st1_q == FULL) && bus.y1_ready;
    rdy    = bus.s ? (st1_q == EMPTY || bus.y1_ready) : (st0_q == EMPTY || bus.y0_ready);
    ld0    = bus.in_valid && rdy && !bus.s;
    ld1    = bus.in_valid && rdy && bus.s;
    st0_d  = ld0 ? FULL : (out0 ? EMPTY : st0_q);
    st1_d  = ld1 ? FULL : (out1 ? EMPTY : st1_q);
    y0_d   = ld0 ? bus.d : y0_q;
    y1_d   = ld1 ? bus.d : y1_q;
    cnt0_d = cnt0_q + {7'd0, out0};
    cnt1_d = cnt1_q + {7'd0, out1};
  end
  always_comb begin
    bus.in_ready = rdy;
    bus.y0       = y0_q;
    bus.y1       = y1_q;
    bus.y0_valid = (st0_q == FULL);
    bus.y1_valid = (st1_q == FULL);
    bus.cnt0     = cnt0_q;
    bus.cnt1     = cnt1_q;
  end
endmodule

// File: tb/tb_demux2_stream.sv
// tb_demux2_stream: directed and randomized self-checking bench for demux2_stream
module tb_demux2_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  demux2_stream_if #(.DATA_W(8)) bus ();
  demux2_stream #(.DATA_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout exp finish");
    $fatal(1, "watchdog");
  end
  task automatic idle_inputs;
    bus.d = '0; bus.s = 1'b0; bus.in_valid = 1'b0; bus.y0_ready = 1'b0; bus.y1_ready = 1'b0;
  endtask
  task automatic do_reset;
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    #2;
    n_chk++;
    if ({bus.y0, bus.y1, bus.cnt0, bus.cnt1, bus.y0_valid, bus.y1_valid} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h exp 0", {bus.y0, bus.y1, bus.cnt0, bus.cnt1, bus.y0_valid, bus.y1_valid});
    end
    bus.s = 1'b1; #1;
    n_chk++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_s1: got %b exp 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.s = 1'b0; bus.d = 8'hC3; bus.in_valid = 1'b1;
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_s0: got %b exp 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_chk++;
    if ({bus.y0_valid, bus.y0} !== {1'b1, 8'hC3}) begin
      n_fail++; $display("FAIL first_transfer: got %h exp %h", {bus.y0_valid, bus.y0}, {1'b1, 8'hC3});
    end
  endtask
  task automatic test_routing;
    do_reset();
    bus.d = 8'hA5; bus.s = 1'b0; bus.in_valid = 1'b1; bus.y0_ready = 1'b1;
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL route_in_ready: got %b exp 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_chk++;
    if ({bus.y0_valid, bus.y0, bus.y1_valid, bus.cnt0} !== {1'b1, 8'hA5, 1'b0, 8'd0}) begin
      n_fail++; $display("FAIL route_load: got %h exp %h", {bus.y0_valid, bus.y0, bus.y1_valid, bus.cnt0}, {1'b1, 8'hA5, 1'b0, 8'd0});
    end
    @(posedge clk); #1;
    n_chk++;
    if ({bus.y0_valid, bus.cnt0} !== {1'b0, 8'd1}) begin
      n_fail++; $display("FAIL route_drain: got %h exp %h", {bus.y0_valid, bus.cnt0}, {1'b0, 8'd1});
    end
  endtask
  task automatic test_backpressure;
    do_reset();
    bus.d = 8'h3C; bus.s = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.d = 8'h77;
    #1;
    n_chk++;
    if ({bus.in_ready, bus.y1_valid, bus.y1} !== {1'b0, 1'b1, 8'h3C}) begin
      n_fail++; $display("FAIL bp_block: got %h exp %h", {bus.in_ready, bus.y1_valid, bus.y1}, {1'b0, 1'b1, 8'h3C});
    end
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({bus.y1_valid, bus.y1, bus.cnt1} !== {1'b1, 8'h3C, 8'd0}) begin
      n_fail++; $display("FAIL bp_hold: got %h exp %h", {bus.y1_valid, bus.y1, bus.cnt1}, {1'b1, 8'h3C, 8'd0});
    end
    bus.y1_ready = 1'b1;
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b exp 1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_chk++;
    if ({bus.y1_valid, bus.y1, bus.cnt1} !== {1'b1, 8'h77, 8'd1}) begin
      n_fail++; $display("FAIL bp_next_word: got %h exp %h", {bus.y1_valid, bus.y1, bus.cnt1}, {1'b1, 8'h77, 8'd1});
    end
    @(posedge clk); #1;
    n_chk++;
    if ({bus.y1_valid, bus.cnt1} !== {1'b0, 8'd2}) begin
      n_fail++; $display("FAIL bp_drained: got %h exp %h", {bus.y1_valid, bus.cnt1}, {1'b0, 8'd2});
    end
  endtask
  task automatic test_independence;
    logic [7:0] w [4];
    w = '{8'h10, 8'h21, 8'h32, 8'h43};
    do_reset();
    bus.d = 8'h5A; bus.s = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.s = 1'b0; bus.y0_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.d = w[i];
      #1;
      n_chk++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL indep_ready_%0d: got %b exp 1", i, bus.in_ready); end
      @(posedge clk); #1;
      n_chk++;
      if ({bus.y0_valid, bus.y0} !== {1'b1, w[i]}) begin
        n_fail++; $display("FAIL indep_word_%0d: got %h exp %h", i, {bus.y0_valid, bus.y0}, {1'b1, w[i]});
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if ({bus.y0_valid, bus.cnt0, bus.cnt1, bus.y1_valid, bus.y1} !== {1'b0, 8'd4, 8'd0, 1'b1, 8'h5A}) begin
      n_fail++; $display("FAIL indep_final: got %h exp %h", {bus.y0_valid, bus.cnt0, bus.cnt1, bus.y1_valid, bus.y1}, {1'b0, 8'd4, 8'd0, 1'b1, 8'h5A});
    end
  endtask
  task automatic test_simultaneous;
    do_reset();
    bus.d = 8'h11; bus.s = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.d = 8'h22; bus.y0_ready = 1'b1;
    #1;
    n_chk++;
    if ({bus.in_ready, bus.y0_valid, bus.y0, bus.cnt0} !== {1'b1, 1'b1, 8'h11, 8'd0}) begin
      n_fail++; $display("FAIL simul_before: got %h exp %h", {bus.in_ready, bus.y0_valid, bus.y0, bus.cnt0}, {1'b1, 1'b1, 8'h11, 8'd0});
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.y0_ready = 1'b0;
    n_chk++;
    if ({bus.y0_valid, bus.y0, bus.cnt0} !== {1'b1, 8'h22, 8'd1}) begin
      n_fail++; $display("FAIL simul_after: got %h exp %h", {bus.y0_valid, bus.y0, bus.cnt0}, {1'b1, 8'h22, 8'd1});
    end
  endtask
  task automatic test_wrap;
    do_reset();
    bus.s = 1'b1; bus.in_valid = 1'b1; bus.y1_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.d = 8'(i);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    n_chk++;
    if ({bus.y1, bus.cnt1} !== {8'hFF, 8'd255}) begin
      n_fail++; $display("FAIL wrap_255: got %h exp %h", {bus.y1, bus.cnt1}, {8'hFF, 8'd255});
    end
    @(posedge clk); #1;
    n_chk++;
    if ({bus.y1_valid, bus.cnt1, bus.cnt0} !== {1'b0, 8'd0, 8'd0}) begin
      n_fail++; $display("FAIL wrap_zero: got %h exp %h", {bus.y1_valid, bus.cnt1, bus.cnt0}, {1'b0, 8'd0, 8'd0});
    end
  endtask
  task automatic test_async_reset;
    do_reset();
    bus.d = 8'hAA; bus.s = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.d = 8'hBB; bus.s = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_chk++;
    if ({bus.y0_valid, bus.y0, bus.y1_valid, bus.y1} !== {1'b1, 8'hAA, 1'b1, 8'hBB}) begin
      n_fail++; $display("FAIL areset_full: got %h exp %h", {bus.y0_valid, bus.y0, bus.y1_valid, bus.y1}, {1'b1, 8'hAA, 1'b1, 8'hBB});
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.y0, bus.y1, bus.cnt0, bus.cnt1, bus.y0_valid, bus.y1_valid, bus.in_ready} !== {34'd0, 1'b1}) begin
      n_fail++; $display("FAIL areset_clear: got %h exp %h", {bus.y0, bus.y1, bus.cnt0, bus.cnt1, bus.y0_valid, bus.y1_valid, bus.in_ready}, {34'd0, 1'b1});
    end
    bus.s = 1'b0; #1;
    n_chk++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_ready_s0: got %b exp 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_random;
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int c0, c1;
    logic exp_rdy;
    c0 = 0; c1 = 0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bus.d = 8'($urandom);
      bus.s = 1'($urandom);
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.y0_ready = 1'($urandom);
      bus.y1_ready = 1'($urandom);
      #1;
      exp_rdy = bus.s ? (q1.size() == 0 || bus.y1_ready) : (q0.size() == 0 || bus.y0_ready);
      n_chk++;
      if (bus.in_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_in_ready cyc %0d: got %b exp %b", n, bus.in_ready, exp_rdy); end
      n_chk++;
      if ({bus.y0_valid, bus.y1_valid, bus.cnt0, bus.cnt1} !== {q0.size() != 0, q1.size() != 0, 8'(c0), 8'(c1)}) begin
        n_fail++; $display("FAIL rnd_state cyc %0d: got %h exp %h", n, {bus.y0_valid, bus.y1_valid, bus.cnt0, bus.cnt1}, {q0.size() != 0, q1.size() != 0, 8'(c0), 8'(c1)});
      end
      if (q0.size() != 0) begin
        n_chk++;
        if (bus.y0 !== q0[0]) begin n_fail++; $display("FAIL rnd_y0 cyc %0d: got %h exp %h", n, bus.y0, q0[0]); end
      end
      if (q1.size() != 0) begin
        n_chk++;
        if (bus.y1 !== q1[0]) begin n_fail++; $display("FAIL rnd_y1 cyc %0d: got %h exp %h", n, bus.y1, q1[0]); end
      end
      @(posedge clk);
      if (q0.size() != 0 && bus.y0_ready) begin void'(q0.pop_front()); c0++; end
      if (q1.size() != 0 && bus.y1_ready) begin void'(q1.pop_front()); c1++; end
      if (bus.in_valid && exp_rdy) begin
        if (bus.s) q1.push_back(bus.d);
        else q0.push_back(bus.d);
      end
      @(negedge clk);
    end
  endtask
  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_independence();
    test_simultaneous();
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
